// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared states, widths and output saturation for the PID step engine
package pid_pkg;

  localparam int U_W   = 12;
  localparam int E_W   = 13;
  localparam int I_W   = 24;
  localparam int ACC_W = 34;

  // Operand select codes for the shared multiplier
  localparam logic [1:0] SEL_E = 2'd0;
  localparam logic [1:0] SEL_I = 2'd1;
  localparam logic [1:0] SEL_D = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_MUL_P,
    S_MUL_I,
    S_MUL_D,
    S_OUT
  } state_e;

  typedef struct packed {
    logic           sat;
    logic [U_W-1:0] val;
  } sat_t;

  // Clip a signed accumulator-width value into the unsigned 12-bit output range
  function automatic sat_t sat_u12(input logic [ACC_W-1:0] r);
    sat_t s;
    if (r[ACC_W-1]) begin
      s.sat = 1'b1;
      s.val = '0;
    end else if (|r[ACC_W-2:U_W]) begin
      s.sat = 1'b1;
      s.val = '1;
    end else begin
      s.sat = 1'b0;
      s.val = r[U_W-1:0];
    end
    return s;
  endfunction

endpackage

// File: rtl/pid_mac.sv
// rtl/pid_mac.sv - single shared signed multiplier with load/add accumulator
module pid_mac
  import pid_pkg::*;
#(
  parameter logic signed [7:0] KP = 8'sd16,
  parameter logic signed [7:0] KI = 8'sd0,
  parameter logic signed [7:0] KD = 8'sd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             add,
  input  logic [1:0]       sel,
  input  logic [E_W-1:0]   e,
  input  logic [I_W-1:0]   integ,
  input  logic [E_W:0]     d,
  output logic [ACC_W-1:0] acc
);

  localparam int P_W = 32;

  logic [7:0]       coef;
  logic [I_W-1:0]   opnd;
  logic [P_W-1:0]   prod;
  logic [ACC_W-1:0] prod_x;
  logic [ACC_W-1:0] acc_d, acc_q;

  // Pick gain/operand pair, form the sign-extended product, then load or accumulate
  always_comb begin
    coef = KP;
    opnd = {{(I_W-E_W){e[E_W-1]}}, e};
    case (sel)
      SEL_I: begin
        coef = KI;
        opnd = integ;
      end
      SEL_D: begin
        coef = KD;
        opnd = {{(I_W-E_W-1){d[E_W]}}, d};
      end
      default: ;
    endcase
    // Low 32 bits of a 32x32 product equal the signed 8x24 product
    prod   = {{(P_W-8){coef[7]}}, coef} * {{(P_W-I_W){opnd[I_W-1]}}, opnd};
    prod_x = {{(ACC_W-P_W){prod[P_W-1]}}, prod};
    acc_d  = acc_q;
    if (load) begin
      acc_d = prod_x;
    end else if (add) begin
      acc_d = acc_q + prod_x;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/pid_step_engine.sv
// rtl/pid_step_engine.sv - sequential PID step, one saturated 12-bit word per sample; PID_ANTIWINDUP_EN clamps the integrator
module pid_step_engine
  import pid_pkg::*;
#(
  parameter logic signed [7:0] KP    = 8'sd16,
  parameter logic signed [7:0] KI    = 8'sd0,
  parameter logic signed [7:0] KD    = 8'sd0,
  parameter int                SHIFT = 4,
  parameter int                I_MAX = 8000
) (
  input  logic           PCLK,
  input  logic           PRESETn,
  input  logic           sp_we,
  input  logic [U_W-1:0] sp_data,
  input  logic           fb_valid,
  input  logic [U_W-1:0] fb_data,
  output logic           fb_ready,
  input  logic           clear,
  output logic [U_W-1:0] u_data,
  output logic           u_valid,
  output logic           u_sat,
  output logic           busy
);

`ifdef PID_ANTIWINDUP_EN
  localparam bit AW_EN = 1'b1;
`else
  localparam bit AW_EN = 1'b0;
`endif

  localparam logic [I_W-1:0] IMAX_P = I_W'(I_MAX);
  localparam logic [I_W-1:0] IMAX_N = ~IMAX_P + 1'b1;

  state_e           state_q, state_d;
  logic [U_W-1:0]   sp_q, sp_d;
  logic [U_W-1:0]   fb_q, fb_d;
  logic [E_W-1:0]   e_q, e_d;
  logic [E_W:0]     d_q, d_d;
  logic [I_W-1:0]   integ_q, integ_d;
  logic [E_W-1:0]   e_prev_q, e_prev_d;
  logic [U_W-1:0]   u_data_q, u_data_d;
  logic             u_sat_q, u_sat_d;
  logic             u_valid_q, u_valid_d;

  logic [E_W-1:0]   e_calc;
  logic [I_W-1:0]   integ_sum;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_shr;
  sat_t             sat_res;
  logic             mac_load, mac_add;
  logic [1:0]       mac_sel;

  // FSM next state, datapath updates and MAC control; clear overrides everything
  always_comb begin
    state_d   = state_q;
    sp_d      = sp_we ? sp_data : sp_q;
    fb_d      = fb_q;
    e_d       = e_q;
    d_d       = d_q;
    integ_d   = integ_q;
    e_prev_d  = e_prev_q;
    u_data_d  = u_data_q;
    u_sat_d   = u_sat_q;
    u_valid_d = 1'b0;
    mac_load  = 1'b0;
    mac_add   = 1'b0;
    mac_sel   = SEL_E;

    e_calc    = {1'b0, sp_q} - {1'b0, fb_q};
    integ_sum = integ_q + {{(I_W-E_W){e_calc[E_W-1]}}, e_calc};
    if (AW_EN) begin
      if ($signed(integ_sum) > $signed(IMAX_P)) begin
        integ_sum = IMAX_P;
      end else if ($signed(integ_sum) < $signed(IMAX_N)) begin
        integ_sum = IMAX_N;
      end
    end
    acc_shr = $signed(acc) >>> SHIFT;
    sat_res = sat_u12(acc_shr);

    case (state_q)
      S_IDLE: begin
        if (fb_valid) begin
          fb_d    = fb_data;
          state_d = S_ERR;
        end
      end
      S_ERR: begin
        e_d     = e_calc;
        d_d     = {e_calc[E_W-1], e_calc} - {e_prev_q[E_W-1], e_prev_q};
        integ_d = integ_sum;
        state_d = S_MUL_P;
      end
      S_MUL_P: begin
        mac_load = 1'b1;
        mac_sel  = SEL_E;
        state_d  = S_MUL_I;
      end
      S_MUL_I: begin
        mac_add = 1'b1;
        mac_sel = SEL_I;
        state_d = S_MUL_D;
      end
      S_MUL_D: begin
        mac_add  = 1'b1;
        mac_sel  = SEL_D;
        e_prev_d = e_q;
        state_d  = S_OUT;
      end
      S_OUT: begin
        u_data_d  = sat_res.val;
        u_sat_d   = sat_res.sat;
        u_valid_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d   = S_IDLE;
      fb_d      = fb_q;
      integ_d   = '0;
      e_prev_d  = '0;
      u_data_d  = u_data_q;
      u_sat_d   = u_sat_q;
      u_valid_d = 1'b0;
      mac_load  = 1'b0;
      mac_add   = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= S_IDLE;
      sp_q      <= '0;
      fb_q      <= '0;
      e_q       <= '0;
      d_q       <= '0;
      integ_q   <= '0;
      e_prev_q  <= '0;
      u_data_q  <= '0;
      u_sat_q   <= 1'b0;
      u_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      fb_q      <= fb_d;
      e_q       <= e_d;
      d_q       <= d_d;
      integ_q   <= integ_d;
      e_prev_q  <= e_prev_d;
      u_data_q  <= u_data_d;
      u_sat_q   <= u_sat_d;
      u_valid_q <= u_valid_d;
    end
  end

  pid_mac #(
    .KP(KP),
    .KI(KI),
    .KD(KD)
  ) u_mac (
    .clk  (PCLK),
    .rst_n(PRESETn),
    .load (mac_load),
    .add  (mac_add),
    .sel  (mac_sel),
    .e    (e_q),
    .integ(integ_q),
    .d    (d_q),
    .acc  (acc)
  );

  assign fb_ready = (state_q == S_IDLE);
  assign busy     = (state_q != S_IDLE);
  assign u_data   = u_data_q;
  assign u_sat    = u_sat_q;
  assign u_valid  = u_valid_q;

endmodule

// File: tb/tb_pid_step_engine.sv
// tb/tb_pid_step_engine.sv - scoreboard bench: four gain sets share one stimulus stream
module tb_pid_step_engine;

  localparam int N = 4;
  localparam logic signed [7:0] KP_T [N] = '{8'sd16, 8'sd0,  8'sd0, 8'sd0};
  localparam logic signed [7:0] KI_T [N] = '{8'sd0,  8'sd16, 8'sd1, 8'sd0};
  localparam logic signed [7:0] KD_T [N] = '{8'sd0,  8'sd0,  8'sd0, 8'sd16};

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b1;
  logic        sp_we = 1'b0;
  logic [11:0] sp_data = '0;
  logic        fb_valid = 1'b0;
  logic [11:0] fb_data = '0;
  logic        clear = 1'b0;
  logic        fb_ready [N];
  logic        busy [N];
  logic        u_valid [N];
  logic        u_sat [N];
  logic [11:0] u_data [N];

  always #5 PCLK = ~PCLK;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pid_step_engine #(
      .KP(KP_T[g]), .KI(KI_T[g]), .KD(KD_T[g]), .SHIFT(4), .I_MAX(8000)
    ) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .sp_we(sp_we), .sp_data(sp_data),
      .fb_valid(fb_valid), .fb_data(fb_data), .fb_ready(fb_ready[g]),
      .clear(clear), .u_data(u_data[g]), .u_valid(u_valid[g]),
      .u_sat(u_sat[g]), .busy(busy[g])
    );
  end

  typedef struct packed {
    logic [31:0]     cyc;
    logic [N-1:0]    s;
    logic [N*12-1:0] u;
  } exp_t;

  exp_t   sb[$];
  int     n_chk = 0;
  int     n_pass = 0;
  int     cyc = 0;
  int     n_valid = 0;
  int     n_acc = 0;
  int     sp_m = 0;
  longint m_integ [N];
  longint m_eprev [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model(input int k, input int sp, input int fb, output int u, output bit s);
    longint e, d, acc, r;
    logic [23:0] w;
    e = sp - fb;
    m_integ[k] = m_integ[k] + e;
`ifdef PID_ANTIWINDUP_EN
    if (m_integ[k] > 8000) m_integ[k] = 8000;
    if (m_integ[k] < -8000) m_integ[k] = -8000;
`else
    w = m_integ[k][23:0];
    m_integ[k] = longint'($signed(w));
`endif
    d = e - m_eprev[k];
    m_eprev[k] = e;
    acc = longint'(KP_T[k]) * e + longint'(KI_T[k]) * m_integ[k] + longint'(KD_T[k]) * d;
    r = acc >>> 4;
    if (r < 0) begin u = 0; s = 1'b1; end
    else if (r > 4095) begin u = 4095; s = 1'b1; end
    else begin u = int'(r); s = 1'b0; end
  endtask

  always @(posedge PCLK) cyc <= cyc + 1;

  // Scoreboard: compare results, and predict what the next edge will start
  always @(negedge PCLK) begin : mon
    exp_t x;
    int   u;
    bit   s;
    int   sp_next;
    if (!PRESETn) begin
      sb.delete();
      sp_m = 0;
      for (int k = 0; k < N; k++) begin m_integ[k] = 0; m_eprev[k] = 0; end
    end else begin
      if (u_valid[0]) begin
        n_valid++;
        if (sb.size() == 0) begin
          check("unexpected_u_valid", 1, 0);
        end else begin
          x = sb.pop_front();
          check("latency_cycle", cyc, x.cyc);
          for (int k = 0; k < N; k++) begin
            check($sformatf("u_valid%0d", k), u_valid[k], 1);
            check($sformatf("u_data%0d", k), u_data[k], x.u[k*12 +: 12]);
            check($sformatf("u_sat%0d", k), u_sat[k], x.s[k]);
          end
        end
      end
      sp_next = sp_we ? int'(sp_data) : sp_m;
      if (clear) begin
        if (sb.size() > 0 && int'(sb[$].cyc) >= cyc + 1) void'(sb.pop_back());
        for (int k = 0; k < N; k++) begin m_integ[k] = 0; m_eprev[k] = 0; end
      end else if (fb_valid && fb_ready[0]) begin
        n_acc++;
        x.cyc = cyc + 6;
        for (int k = 0; k < N; k++) begin
          model(k, sp_next, int'(fb_data), u, s);
          x.u[k*12 +: 12] = 12'(u);
          x.s[k] = s;
        end
        sb.push_back(x);
      end
      sp_m = sp_next;
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic write_sp(input int v);
    sp_we = 1'b1;
    sp_data = 12'(v);
    tick();
    sp_we = 1'b0;
  endtask

  task automatic send(input int fb);
    int t;
    t = 0;
    while (!fb_ready[0] && t < 20) begin tick(); t++; end
    if (!fb_ready[0]) check("ready_timeout", 0, 1);
    fb_valid = 1'b1;
    fb_data = 12'(fb);
    tick();
    fb_valid = 1'b0;
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin tick(); t++; end
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int v0, a0;
    #2 PRESETn = 1'b0;
    repeat (3) tick();
    PRESETn = 1'b1;
    tick();
    check("rst_u_data", u_data[0], 0);
    check("rst_u_valid", u_valid[0], 0);
    check("rst_u_sat", u_sat[0], 0);
    check("rst_fb_ready", fb_ready[0], 1);
    check("rst_busy", busy[0], 0);

    // Proportional
    write_sp(1000);
    send(900);
    drain();
    check("p_e100", u_data[0], 100);
    check("p_e100_sat", u_sat[0], 0);
    send(1100);
    drain();
    check("p_neg", u_data[0], 0);
    check("p_neg_sat", u_sat[0], 1);

    // Integral
    clear_pulse();
    send(900);
    send(900);
    drain();
    check("i_second", u_data[1], 200);
    clear_pulse();
    send(900);
    drain();
    check("i_after_clear", u_data[1], 100);

    // Derivative
    clear_pulse();
    send(900);
    drain();
    check("d_first", u_data[3], 100);
    write_sp(1050);
    send(900);
    drain();
    check("d_second", u_data[3], 50);

    // Integrator windup
    clear_pulse();
    write_sp(4095);
    repeat (3) send(0);
    drain();
`ifdef PID_ANTIWINDUP_EN
    check("aw_third", u_data[2], 500);
`else
    check("aw_third", u_data[2], 767);
`endif

    // fb_valid held through busy periods
    clear_pulse();
    write_sp(2000);
    v0 = n_valid;
    a0 = n_acc;
    fb_valid = 1'b1;
    fb_data = 12'd1990;
    repeat (24) tick();
    fb_valid = 1'b0;
    drain();
    check("hold_accepts", n_acc - a0, 4);
    check("hold_valids", n_valid - v0, 4);

    // clear while in MUL_I
    v0 = n_valid;
    send(1500);
    repeat (2) tick();
    clear_pulse();
    check("clr_busy", busy[0], 0);
    check("clr_ready", fb_ready[0], 1);
    repeat (8) tick();
    check("clr_no_valid", n_valid - v0, 0);
    check("clr_hold_data", u_data[0], 10);

    // reset while in MUL_D
    send(1500);
    repeat (3) tick();
    PRESETn = 1'b0;
    #1;
    check("mrst_u_data", u_data[0], 0);
    check("mrst_u_valid", u_valid[0], 0);
    check("mrst_u_sat", u_sat[0], 0);
    check("mrst_busy", busy[0], 0);
    check("mrst_ready", fb_ready[0], 1);
    repeat (2) tick();
    PRESETn = 1'b1;
    v0 = n_valid;
    repeat (8) tick();
    check("mrst_no_valid", n_valid - v0, 0);
    write_sp(500);
    send(400);
    drain();
    check("post_rst", u_data[0], 100);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pid_step_engine.md
# pid_step_engine

Sequential PID compute stage downstream of the APB register bridge. It consumes the 12-bit setpoint written over APB (`data_pid_out` qualified by `write_enablepid`) and accepts feedback samples through a valid/ready handshake. It computes one saturated 12-bit control word per sample using a single shared multiplier, and returns the result for APB readback on the bridge's `data_pid_in`.

## Interface
Parameters:
- `KP`, default 16: proportional gain, signed 8-bit, Q4.4.
- `KI`, default 0: integral gain, signed 8-bit, Q4.4.
- `KD`, default 0: derivative gain, signed 8-bit, Q4.4.
- `SHIFT`, default 4: arithmetic right shift applied to the accumulated sum.
- `I_MAX`, default 8000: integrator clamp magnitude, positive, below 2^23. Used only with the anti-windup macro.

Ports (one clock; reset is asynchronous and active-low):
- `PCLK` in 1: clock.
- `PRESETn` in 1: asynchronous active-low reset.
- `sp_we` in 1: setpoint write strobe (bridge `write_enablepid`).
- `sp_data` in 12: setpoint value, unsigned (bridge `data_pid_out`).
- `fb_valid` in 1: feedback sample valid.
- `fb_data` in 12: feedback sample, unsigned.
- `fb_ready` out 1: ready for a sample; high only in IDLE.
- `clear` in 1: synchronous clear of the integrator and previous error; aborts any computation in flight.
- `u_data` out 12: control output, unsigned, held between updates (to bridge `data_pid_in`).
- `u_valid` out 1: one-cycle pulse when `u_data` updates.
- `u_sat` out 1: set when the last result was clipped; updates together with `u_data`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `sp_reg` loads `sp_data` on any cycle where `sp_we` is high, regardless of state.
- A sample is accepted on a rising edge where `fb_valid` and `fb_ready` are both high. `fb_data` is latched at that edge. While not ready, `fb_valid` is ignored and is not queued.
- FSM sequence: IDLE → ERR → MUL_P → MUL_I → MUL_D → OUT → IDLE.
  - ERR: `e = sp_reg - fb` (signed 13-bit); `integ += e`; `d = e - e_prev` (signed 14-bit).
  - MUL_P: `acc = KP*e`.
  - MUL_I: `acc += KI*integ`.
  - MUL_D: `acc += KD*d`; `e_prev <= e`.
  - OUT: `r = acc >>> SHIFT`. If `r < 0`, output 0 with `u_sat=1`. If `r > 4095`, output 4095 with `u_sat=1`. Otherwise output `r` with `u_sat=0`. `u_valid` pulses.
- Widths:
  - `integ` is signed 24-bit.
  - `acc` is signed 34-bit; it cannot overflow for legal parameters.
  - Multiplier operands are sign-extended.
- `clear` is effective in any state. It zeroes `integ` and `e_prev`, forces IDLE, and suppresses `u_valid` for the aborted sample. `u_data` and `u_sat` hold their values.
- `clear` and sample accept on the same edge: `clear` wins and the sample is dropped.
- `sp_we` during a computation: the new setpoint is used from the next ERR. `sp_we` on the accept edge: that sample's ERR uses the new value.

## Timing
- Reset values:
  - `u_data` = 0, `u_valid` = 0, `u_sat` = 0, `busy` = 0, `fb_ready` = 1.
  - `sp_reg`, `integ`, `e_prev`, `acc` = 0; state = IDLE.
- Latency: `u_valid` is high in the cycle following the 5th rising edge after the accept edge. `u_data` is valid in that same cycle.
- Throughput: one sample per 6 cycles. `fb_ready` rises in the same cycle that `u_valid` is high, so back-to-back accept is allowed.
- Reset asserted mid-computation: returns immediately to reset values; no `u_valid`.

## Configuration
- `PID_ANTIWINDUP_EN` defined: after the ERR update, `integ` is clamped to [-`I_MAX`, +`I_MAX`].
- Undefined: `integ` wraps modulo 2^24 (two's complement); `I_MAX` is unused.

## Structure
- Package `pid_pkg` holds:
  - the state enum;
  - width constants (`U_W=12`, `E_W=13`, `I_W=24`, `ACC_W=34`);
  - the `sat_u12` function.
- Sub-module `pid_mac`: one signed multiplier plus accumulator, with load/add control and operand select driven by the FSM.

## Test plan
- Reset: release `PRESETn` → `u_data=0`, `u_valid=0`, `fb_ready=1`, `busy=0`.
- Proportional (KP=16, KI=0, KD=0, SHIFT=4): `sp=1000`, `fb=900` → `u_data=100`, `u_sat=0`, one-cycle `u_valid` after 5 edges. Then `fb=1100` → `u_data=0`, `u_sat=1`.
- Integral (KP=0, KI=16): two samples with `e=100` → `u_data` 100, then 200. Then `clear`, then one sample `e=100` → 100.
- Anti-windup (KP=0, KI=1, SHIFT=4, I_MAX=8000, `sp=4095`, `fb=0`), three samples:
  - with `PID_ANTIWINDUP_EN`: 255, 500, 500;
  - without: 255, 511, 767.
- Derivative (KP=0, KD=16): `e=100` then `e=150` → 100, then 50.
- Handshake and aborts:
  - `fb_valid` held high during `busy` → no extra accept; exactly one `u_valid` per 6 cycles.
  - `clear` in MUL_I → no `u_valid`, IDLE next cycle.
  - `PRESETn` low in MUL_D → all outputs return to reset values.
